// File: rtl/sm_mult_seq.sv
// sm_mult_seq: sequential shift-add multiplier for sign-magnitude operands.
// Feeds 21-bit (at MAG_W=10) sign-magnitude products to the neuron accumulation adders.
// One multiply in flight; valid/ready handshake on both sides.
//
// Ports:
//   clk        system clock, all state updates on rising edge
//   rst        synchronous active-high reset, aborts any multiply in progress
//   in_valid   operand pair valid
//   in_ready   block can accept an operand pair (high only in idle)
//   a, b       operands, bit MAG_W = sign, bits MAG_W-1:0 = magnitude
//   out_valid  product valid, held until out_ready
//   out_ready  downstream accepts the product
//   out        product, bit 2*MAG_W = sign, lower bits = magnitude
//
// Optional build macro SM_MULT_EARLY_TERM_EN: leave the busy phase as soon as
// no multiplier bits remain, so latency depends on the highest set bit of |b|.

module sm_mult_seq #(
   parameter int unsigned MAG_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MAG_W:0]     a,
   input  logic [MAG_W:0]     b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*MAG_W:0]   out
);

   localparam int unsigned PROD_W = 2 * MAG_W;
   localparam int unsigned STEP_W = $clog2(MAG_W + 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e              state_q, state_d;
   logic [PROD_W-1:0]   mcand_q, mcand_d;
   logic [PROD_W-1:0]   acc_q, acc_d;
   logic [MAG_W-1:0]    mplier_q, mplier_d;
   logic                sign_q, sign_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [PROD_W:0]     out_q, out_d;
   logic                last_step;

   // Final busy cycle: all MAG_W multiplier bits consumed, or (early-term
   // build) nothing left in the multiplier after this cycle's shift.
   always_comb begin
`ifdef SM_MULT_EARLY_TERM_EN
      last_step = (step_q == STEP_W'(MAG_W - 1)) || ((mplier_q >> 1) == '0);
`else
      last_step = (step_q == STEP_W'(MAG_W - 1));
`endif
   end

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         sign_q   <= 1'b0;
         step_q   <= '0;
         out_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         sign_q   <= sign_d;
         step_q   <= step_d;
         out_q    <= out_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid)  state_d = StBusy;
         StBusy:  if (last_step) state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state
   always_comb begin
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      sign_d   = sign_q;
      step_d   = step_q;
      out_d    = out_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               mcand_d  = PROD_W'(a[MAG_W-1:0]);
               mplier_d = b[MAG_W-1:0];
               sign_d   = a[MAG_W] ^ b[MAG_W];
               acc_d    = '0;
               step_d   = '0;
            end
         end
         StBusy: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            step_d   = step_q + 1'b1;
            // Capture the product on the last step; a zero magnitude is forced
            // positive so negative zero never reaches the adders.
            if (last_step) out_d = {(acc_d != '0) & sign_q, acc_d};
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
      out       = out_q;
   end

endmodule

// File: tb/tb_sm_mult_seq.sv
module tb_sm_mult_seq;

   localparam int W = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W:0]    a = '0;
   logic [W:0]    b = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [2*W:0]  out;

   sm_mult_seq #(.MAG_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   typedef struct {
      logic [2*W:0] prod;
      int           lat;
      int           acc_cyc;
   } exp_t;

   exp_t sb[$];

   function automatic logic [2*W:0] model_out(input logic [W:0] av, input logic [W:0] bv);
      logic [2*W-1:0] m;
      m = av[W-1:0] * bv[W-1:0];
      return {(m != 0) && (av[W] ^ bv[W]), m};
   endfunction

   function automatic int model_lat(input logic [W:0] bv);
`ifdef SM_MULT_EARLY_TERM_EN
      int n;
      n = 1;
      for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
      return n + 1;
`else
      return W + 1;
`endif
   endfunction

   // Scoreboard monitor, samples on the falling edge
   int           rise_cyc = 0;
   int           hs_cyc = -10;
   bit           prev_valid = 0;
   bit           prev_hs = 0;
   logic [2*W:0] prev_out = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 0;
         prev_hs = 0;
      end else begin
         if (prev_hs) begin
            check_eq("post_xfer_valid", out_valid, 0);
            check_eq("post_xfer_ready", in_ready, 1);
         end
         if (out_valid && prev_valid) check_eq("out_hold", out, prev_out);
         if (out_valid && !prev_valid) rise_cyc = cyc;
         if (out_valid) check_eq("ready_low_in_done", in_ready, 0);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_eq("spurious_out", out_valid, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_eq("product", out, e.prod);
               check_eq("latency", rise_cyc - e.acc_cyc, e.lat);
            end
            hs_cyc = cyc;
            prev_hs = 1;
         end else begin
            prev_hs = 0;
         end
         prev_valid = out_valid;
         prev_out = out;
      end
   end

   task automatic push_exp(input logic [W:0] av, input logic [W:0] bv);
      exp_t e;
      e.prod = model_out(av, bv);
      e.lat = model_lat(bv);
      e.acc_cyc = cyc;
      sb.push_back(e);
   endtask

   // Offer a pair until accepted; drop in_valid after the accepting edge if asked.
   task automatic send(input logic [W:0] av, input logic [W:0] bv, input bit track,
                       input bit drop);
      bit done;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge clk); #2;
         in_valid = 1'b1;
         a = av;
         b = bv;
         if (in_ready) begin
            if (track) push_exp(av, bv);
            done = 1;
         end
      end
      if (!done) check_eq("send_timeout", in_ready, 1);
      if (drop) begin
         @(posedge clk); #2;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      check_eq("drain_empty", sb.size(), 0);
   endtask

   initial begin
      logic [W:0] ra, rb;
      bit         got;
      int         base;

      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out", out, 0);

      // Directed products
      send({1'b1, 10'd5}, {1'b0, 10'd3}, 1, 1);
      drain();
      send({1'b1, 10'd1023}, {1'b1, 10'd1023}, 1, 1);
      drain();
      send({1'b1, 10'd7}, {1'b0, 10'd0}, 1, 1);
      drain();
      send({1'b0, 10'd0}, {1'b1, 10'd9}, 1, 1);
      drain();

      // Backpressure: hold out_ready low for 5 cycles of out_valid
      out_ready = 1'b0;
      send({1'b0, 10'd2}, {1'b0, 10'd4}, 1, 1);
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (out_valid) got = 1;
         else begin
            @(posedge clk); #2;
         end
      end
      check_eq("bp_valid_rose", got, 1);
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_in_ready", in_ready, 0);
         check_eq("bp_out_valid", out_valid, 1);
         check_eq("bp_out", out, 21'd8);
         @(posedge clk); #2;
      end
      out_ready = 1'b1;
      drain();

      // Reset in the middle of a busy phase
      send({1'b0, 10'd9}, {1'b0, 10'd9}, 0, 0);
      base = cyc;
      while (cyc < base + 4) begin
         @(posedge clk); #2;
         in_valid = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      check_eq("midrst_in_ready", in_ready, 1);
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_out", out, 0);
      repeat (15) @(posedge clk);
      #2;
      check_eq("midrst_quiet", out_valid, 0);
      send({1'b0, 10'd2}, {1'b0, 10'd2}, 1, 1);
      drain();

      // in_valid held through busy/done with changing operands
      send({1'b0, 10'd3}, {1'b0, 10'd5}, 1, 0);
      got = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(posedge clk); #2;
         if (in_ready) begin
            a = {1'b0, 10'd6};
            b = {1'b1, 10'd7};
            push_exp(a, b);
            check_eq("reaccept_cycle", cyc, hs_cyc + 1);
            got = 1;
         end else begin
            a = W'($urandom_range(0, 2047));
            b = W'($urandom_range(0, 2047));
         end
      end
      check_eq("reaccept_seen", got, 1);
      @(posedge clk); #2;
      in_valid = 1'b0;
      drain();

      // Random back-to-back products
      for (int i = 0; i < 8; i++) begin
         ra = (W + 1)'($urandom_range(0, 2047));
         rb = (W + 1)'($urandom_range(0, 2047));
         send(ra, rb, 1, 1);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/sm_mult_seq.md
Name: sm_mult_seq

Overview:
- Sequential shift-add multiplier for sign-magnitude operands.
- Produces the 21-bit sign-magnitude products (bit 20 = sign, bits 19:0 = magnitude) consumed by the MLP neuron accumulation adders. It is the producer end of that adder-input format.
- Sits between the input/weight memories and the neuron accumulator.
- Uses a valid/ready handshake on both sides and one multiply in flight at a time.

Parameters:
- MAG_W, default 10: operand magnitude width. Operand width is MAG_W+1; product width is 2*MAG_W+1 (21 at default).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair (high only in IDLE).
- a  input  MAG_W+1  multiplicand (data); bit MAG_W is the sign, lower bits are the magnitude.
- b  input  MAG_W+1  multiplier (weight); same format as a.
- out_valid  output  1  product valid.
- out_ready  input  1  downstream accepts the product.
- out  output  2*MAG_W+1  product; bit 2*MAG_W is the sign, lower bits are the magnitude.

Behaviour:
- Reset:
  - state=IDLE; out=0; out_valid=0; in_ready=1.
  - Internal accumulator, shift registers and step counter are cleared.
  - Reset mid-operation aborts the multiply with no output produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid (cycle T):
    - latch mcand = zero-extended a magnitude (2*MAG_W bits);
    - latch mplier = b magnitude;
    - latch sign = a[MAG_W] XOR b[MAG_W];
    - clear acc and step; go to BUSY.
- BUSY:
  - in_ready=0; a, b and in_valid are ignored.
  - Each cycle: if mplier[0], acc <= acc + mcand. Then mcand <<= 1, mplier >>= 1, step += 1.
  - After exactly MAG_W BUSY cycles, go to DONE.
- DONE:
  - out_valid=1, asserted at cycle T+MAG_W+1.
  - out = {sign_final, acc}, where sign_final = 0 if acc==0, else sign. Negative zero is never emitted.
  - out and out_valid hold stable while out_ready=0.
  - When out_ready=1: transfer completes that cycle; next cycle is IDLE with out_valid=0 and in_ready=1.
  - out keeps its last value after the transfer; only out_valid marks it as meaningful.
- Latency and throughput:
  - Latency from accept to out_valid is MAG_W+1 cycles (11 at default).
  - Minimum issue interval is MAG_W+2 cycles. No overlap between consecutive operations.
- Arithmetic:
  - acc is 2*MAG_W bits.
  - Max magnitude (2^MAG_W-1)^2 fits without overflow, so no saturation is needed.
- Simultaneous events:
  - rst has priority over every handshake.
  - in_valid during BUSY or DONE is not accepted; the upstream holds it.

Optional Feature:
- Macro: SM_MULT_EARLY_TERM_EN.
- Defined:
  - In BUSY, if the shifted mplier for the next cycle is zero (all remaining multiplier bits zero), go to DONE on the next edge.
  - BUSY cycle count = max(1, position of highest set bit of |b| + 1).
  - Latency = that count + 1. The product value is identical to the non-early-terminated result.
- Undefined:
  - BUSY always lasts exactly MAG_W cycles.
  - Latency is fixed at MAG_W+1 regardless of operand values.

Test Plan:
- a=-5 {1,10'd5}, b=+3 {0,10'd3}, out_ready=1 → out=21'h100000|15 (sign 1, mag 15).
  - out_valid at T+11 for one cycle; with EARLY_TERM_EN, out_valid at T+3.
- a=-1023, b=-1023 → out sign 0, mag 1046529 (20'hFF801), no overflow. Latency 11 in both builds.
- a=-7, b=+0 → out=0 (sign forced 0, no negative zero).
  - With EARLY_TERM_EN, out_valid at T+2.
- Backpressure: a=+2, b=+4, out_ready=0 for 5 cycles after out_valid rises → out=8 stable, out_valid held, in_ready=0 throughout.
  - Transfer on the out_ready pulse; in_ready=1 the next cycle.
- Reset mid-BUSY: accept a=+9, b=+9, assert rst at T+4 for one cycle → out_valid never rises, in_ready=1 after reset.
  - A new pair +2×+2 then yields out=4.
- in_valid held high through BUSY with changing a/b → only the pair sampled at T is used; the next accept occurs exactly in the IDLE cycle after the output transfer.
